// File: rtl/fifo_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the requester handshake and the FIFO write/credit signals that
//   surround fifo_wr_arbiter.
//   slave  : arbiter side (consumes requests and FIFO status, drives grants,
//            the FIFO write port and the credit count)
//   master : environment side (requesters + FIFO)
//   req_valid   [NREQ]     requester i has data
//   req_data    [NREQ*DW]  requester i data in bits [i*DW +: DW]
//   req_ready   [NREQ]     one-hot grant
//   fifo_write  [1]        FIFO write strobe
//   fifo_wrData [DW]       FIFO write data
//   fifo_read   [1]        FIFO read strobe
//   fifo_empty  [1]        FIFO empty flag
//   credits     [CW]       free FIFO slots not yet reserved
// ----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_write;
    logic [DW-1:0]      fifo_wrData;
    logic               fifo_read;
    logic               fifo_empty;
    logic [CW-1:0]      credits;

    modport slave (
        input  req_valid, req_data, fifo_read, fifo_empty,
        output req_ready, fifo_write, fifo_wrData, credits
    );

    modport master (
        output req_valid, req_data, fifo_read, fifo_empty,
        input  req_ready, fifo_write, fifo_wrData, credits
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single write port of one sync_fifo among
//   NREQ requesters. One request is accepted per cycle, registered, and
//   written into the FIFO on the following cycle. A credit counter mirrors
//   FIFO free space; the slot is reserved at accept time so the in-flight
//   registered write can never land in a full FIFO.
// Ports
//   i_clk   clock, rising edge
//   i_rst   asynchronous reset, active low (also resets the FIFO)
//   bus     fifo_wr_arbiter_if.slave (requester handshake + FIFO port)
//   o_stat_grants [NREQ*16]  per-requester accept counters (ARB_STATS_EN)
//   o_stat_stall  [16]       cycles with any request but no credit (ARB_STATS_EN)
// Configuration
//   ARB_STATS_EN  when defined, adds the statistics counters and ports.
// ----------------------------------------------------------------------------

`ifdef ARB_STATS_EN
// Wrapping 16-bit event counter, one per statistic lane.
module arb_stat_ctr (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)     o_cnt <= '0;
        else if (i_inc) o_cnt <= o_cnt + 16'd1;
    end
endmodule
`endif

module fifo_wr_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int DW    = 32,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fifo_wr_arbiter_if.slave     bus
`ifdef ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   o_stat_grants,
    output logic [15:0]          o_stat_stall
`endif
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_credits;
    logic            r_write;
    logic [DW-1:0]   r_wdata;

    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_hit;
    logic [IW-1:0]   w_gidx;
    logic            w_found;
    logic            w_accept;
    logic            w_inc;

    // Search from r_ptr upward with wrap. The loop runs from the farthest
    // candidate back to r_ptr so the last hit (the nearest) wins. Grants are
    // gated only by the registered credit count, never by fifo_read.
    always_comb begin
        w_gidx  = '0;
        w_found = 1'b0;
        w_grant = '0;
        if (r_credits != '0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
                    w_gidx  = IW'((int'(r_ptr) + k) % NREQ);
                    w_found = 1'b1;
                end
            end
        end
        if (w_found && i_rst) w_grant[w_gidx] = 1'b1;
    end

    assign w_hit    = w_grant & bus.req_valid;
    assign w_accept = |w_hit;
    assign w_inc    = bus.fifo_read & ~bus.fifo_empty;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ptr     <= '0;
            r_credits <= CW'(DEPTH);
            r_write   <= 1'b0;
            r_wdata   <= '0;
        end else begin
            r_write <= w_accept;
            if (w_accept) begin
                r_ptr   <= (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
                r_wdata <= bus.req_data[w_gidx*DW +: DW];
            end
            // Accept and a real read in the same cycle cancel out.
            case ({w_accept, w_inc})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign bus.req_ready   = w_grant;
    assign bus.fifo_write  = r_write;
    assign bus.fifo_wrData = r_wdata;
    assign bus.credits     = r_credits;

    a_credit_range: assert property (@(posedge i_clk) disable iff (!i_rst)
        r_credits <= CW'(DEPTH));

`ifdef ARB_STATS_EN
    arb_stat_ctr u_grant_ctr [NREQ-1:0] (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_hit),
        .o_cnt (o_stat_grants)
    );

    arb_stat_ctr u_stall_ctr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc ((|bus.req_valid) && (r_credits == '0)),
        .o_cnt (o_stat_stall)
    );
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed scenarios followed by a randomized phase. A queue stands in for
//   the FIFO; arbitration, credits and the one-cycle write latency are
//   predicted from the round-robin rule with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) bus ();

`ifdef ARB_STATS_EN
    logic [NREQ*16-1:0] stat_grants;
    logic [15:0]        stat_stall;
`endif

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .bus           (bus)
`ifdef ARB_STATS_EN
        ,
        .o_stat_grants (stat_grants),
        .o_stat_stall  (stat_stall)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    int          m_ptr;
    int          m_cred;
    bit          m_wr;
    logic [31:0] m_wdata;
    logic [31:0] q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_cred  = DEPTH;
        m_wr    = 1'b0;
        m_wdata = '0;
        q.delete();
    endtask

    function automatic int ref_grant(input logic [NREQ-1:0] v);
        if (m_cred == 0) return -1;
        for (int k = 0; k < NREQ; k++)
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    // One cycle, entered and left just after a falling edge.
    task automatic step(input logic [NREQ-1:0] v, input logic rd, output int gi);
        int   g;
        logic emp;
        logic [NREQ-1:0] exp_rdy;
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = $urandom;
        bus.fifo_read  = rd;
        emp            = (q.size() == 0);
        bus.fifo_empty = emp;
        #1;
        g       = ref_grant(v);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        gi = -1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gi = i;
        check("ready", bus.req_ready, exp_rdy);
        check("credits", bus.credits, m_cred);
        check("fifo_write", bus.fifo_write, m_wr);
        if (m_wr) check("fifo_wrData", bus.fifo_wrData, m_wdata);
        check("invariant", int'(bus.credits) + q.size() + int'(bus.fifo_write), DEPTH);
        @(posedge i_clk);
        if (rd && !emp) void'(q.pop_front());
        if (m_wr) begin
            check("no_overflow", q.size() < DEPTH, 1'b1);
            q.push_back(m_wdata);
        end
        m_wr = (g >= 0);
        if (g >= 0) begin
            m_wdata = bus.req_data[g*DW +: DW];
            m_ptr   = (g + 1) % NREQ;
        end
        m_cred = m_cred + ((rd && !emp) ? 1 : 0) - ((g >= 0) ? 1 : 0);
        @(negedge i_clk);
    endtask

    initial begin
        int gi;
        int t1_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.fifo_read  = 1'b0;
        bus.fifo_empty = 1'b1;
        model_reset();

        // Reset state, with requests present to show grants are held off.
        repeat (2) @(negedge i_clk);
        bus.req_valid = '1;
        #1;
        check("rst_credits", bus.credits, DEPTH);
        check("rst_write", bus.fifo_write, 1'b0);
        check("rst_wrData", bus.fifo_wrData, 32'h0);
        check("rst_ready", bus.req_ready, 4'h0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // Read while empty is not a credit.
        step(4'h0, 1'b1, gi);
        check("empty_read_cred", bus.credits, DEPTH);

        // T1 / T6: all requesters valid for 12 cycles, no reads.
        for (int c = 0; c < 12; c++) begin
            step(4'hF, 1'b0, gi);
            if (c < 8) check("t1_order", gi, t1_exp[c]);
            else       check("t1_stalled", gi, -1);
        end
        check("t1_credits_zero", bus.credits, 0);
`ifdef ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) check("t6_grants", stat_grants[i*16 +: 16], 16'd2);
        check("t6_stall", stat_stall, 16'd4);
`endif

        // T2: no credit; a read frees one slot usable next cycle.
        step(4'hF, 1'b1, gi);
        check("t2_no_grant", gi, -1);
        check("t2_credit_back", bus.credits, 1);
        step(4'hF, 1'b0, gi);
        check("t2_grant", gi, 0);
        check("t2_credits_zero", bus.credits, 0);

        // T4: credits==1 with accept and read together.
        step(4'h0, 1'b1, gi);
        step(4'hF, 1'b1, gi);
        check("t4_grant", gi, 1);
        check("t4_credits_hold", bus.credits, 1);
        step(4'hF, 1'b0, gi);
        check("t4_next_grant", gi, 2);

        // T3: only requester 2 valid; back-to-back grants.
        repeat (4) step(4'h0, 1'b1, gi);
        for (int c = 0; c < 3; c++) begin
            step(4'b0100, 1'b0, gi);
            check("t3_req2", gi, 2);
        end
        step(4'h0, 1'b0, gi);

        // T5: reset while a write is in flight.
        step(4'b0001, 1'b0, gi);
        check("t5_write_pending", bus.fifo_write, 1'b1);
        bus.req_valid = 4'hF;
        i_rst = 1'b0;
        #1;
        check("t5_write_dropped", bus.fifo_write, 1'b0);
        check("t5_credits", bus.credits, DEPTH);
        check("t5_ready", bus.req_ready, 4'h0);
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        step(4'hF, 1'b0, gi);
        check("t5_first_grant", gi, 0);

        // Randomized traffic, alternating fill-heavy and drain-heavy phases.
        for (int c = 0; c < 600; c++) begin
            int pct;
            pct = ((c / 100) % 2 == 0) ? 25 : 75;
            step(NREQ'($urandom), ($urandom_range(0, 99) < pct), gi);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
